image_gaussian_filter_cfg: RTL and testbench

Parametrised, mode-selectable 3×3 smoothing filter for the VIP gray-scale pipeline. It sits between the gray conversion stage and the Sobel/NMS stages of the Canny chain. It carries its own two-line buffer and row/column counters, so it clamps taps at the top and left frame borders instead of mixing in stale line data. It adds round-to-nearest, a per-frame latched kernel mode and a line-overflow status flag.

---
 rtl/gauss_filter_pkg.sv | 43 ++++
 rtl/image_line_buffer.sv | 30 +++
 rtl/image_gaussian_filter_cfg.sv | 172 +++++++++++++++++
 tb/tb_image_gaussian_filter_cfg.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_filter_pkg.sv
// Shared encodings and kernel constants for the gray-scale 3x3 smoothing filter.
// Kernels are flattened row-major, tap index = row*3 + col, row 0 = oldest line.
package gauss_filter_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_GAUSS  = 2'd1,
        MODE_CROSS  = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    localparam int PIPE_LAT    = 3;
    localparam int GAUSS_SHIFT = 4;
    localparam int CROSS_SHIFT = 3;

    localparam logic [8:0][2:0] GAUSS_K  = {3'd1, 3'd2, 3'd1,
                                            3'd2, 3'd4, 3'd2,
                                            3'd1, 3'd2, 3'd1};
    localparam logic [8:0][2:0] CROSS_K  = {3'd0, 3'd1, 3'd0,
                                            3'd1, 3'd4, 3'd1,
                                            3'd0, 3'd1, 3'd0};
    // Bypass selects only the newest tap (row r, col c), which is the input pixel.
    localparam logic [8:0][2:0] BYPASS_K = {3'd1, 3'd0, 3'd0,
                                            3'd0, 3'd0, 3'd0,
                                            3'd0, 3'd0, 3'd0};

    function automatic logic [2:0] kweight(input mode_e m, input logic [3:0] k);
        case (m)
            MODE_GAUSS: kweight = GAUSS_K[k];
            MODE_CROSS: kweight = CROSS_K[k];
            default:    kweight = BYPASS_K[k];
        endcase
    endfunction

    function automatic logic [2:0] kshift(input mode_e m);
        case (m)
            MODE_GAUSS: kshift = 3'(GAUSS_SHIFT);
            MODE_CROSS: kshift = 3'(CROSS_SHIFT);
            default:    kshift = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/image_line_buffer.sv
// Two cascaded line RAMs: reading col c yields rows r-1 and r-2, then the
// current pixel is written and the old r-1 entry drops into the r-2 RAM.
module image_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int AW         = $clog2(IMG_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_addr,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic [DATA_WIDTH-1:0] o_row1,
    output logic [DATA_WIDTH-1:0] o_row2
);
    import gauss_filter_pkg::*;

    logic [DATA_WIDTH-1:0] r_ram1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] r_ram2 [IMG_WIDTH];

    assign o_row1 = r_ram1[i_addr];
    assign o_row2 = r_ram2[i_addr];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_ram1[i_addr] <= i_din;
            r_ram2[i_addr] <= r_ram1[i_addr];
        end
    end

endmodule

// File: rtl/image_gaussian_filter_cfg.sv
// Mode-selectable 3x3 smoothing filter with top/left edge replication, a
// per-frame latched kernel, sticky line-overflow flag and fixed 3-cycle latency.
module image_gaussian_filter_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            cfg_mode,
    input  logic                  per_frame_vsync,
    input  logic                  per_frame_href,
    input  logic                  per_frame_clken,
    input  logic [DATA_WIDTH-1:0] per_img_gray,
    output logic                  post_frame_vsync,
    output logic                  post_frame_href,
    output logic                  post_frame_clken,
    output logic [DATA_WIDTH-1:0] post_img_gray,
    output logic                  line_overflow
);
    import gauss_filter_pkg::*;

    localparam int ACC_W = DATA_WIDTH + 4;
    localparam int CW    = $clog2(IMG_WIDTH + 1);
    localparam int AW    = $clog2(IMG_WIDTH);
    localparam int RW    = 16;

    logic                 r_vs_d, r_hr_d, r_armed, r_ovf;
    logic [CW-1:0]        r_col;
    logic [RW-1:0]        r_row;
    mode_e                r_mode, r_mode_s1, r_mode_s2;
    logic [PIPE_LAT-1:0]  r_vs_pipe, r_hr_pipe, r_ck_pipe;
    logic [1:0]           r_vld_pipe;
    logic [2:0][DATA_WIDTH-1:0]      r_cm1, r_cm2;
    logic [2:0][2:0][DATA_WIDTH-1:0] r_win;
    logic [2:0][ACC_W-1:0]           r_rsum;
    logic [DATA_WIDTH-1:0]           r_gray;

    logic                 w_vs_rise, w_hr_fall, w_en, w_acc, w_ovf, w_row0, w_row1;
    logic                 w_c0, w_c1;
    mode_e                w_mode;
    logic [AW-1:0]        w_tcol;
    logic [DATA_WIDTH-1:0] w_lb1, w_lb2;
    logic [2:0][DATA_WIDTH-1:0]  w_colv;
    logic [2:0][2:0][ACC_W-1:0]  w_prod;
    logic [ACC_W-1:0]     w_sum, w_rnd, w_res;
    logic [2:0]           w_sh;

    assign w_vs_rise = per_frame_vsync & ~r_vs_d;
    assign w_hr_fall = ~per_frame_href & r_hr_d;
    // The arming vsync edge itself is already part of the frame.
    assign w_en      = r_armed | w_vs_rise;
    assign w_acc     = w_en & per_frame_href & per_frame_clken;
    assign w_ovf     = w_acc & (r_col == CW'(IMG_WIDTH));
    assign w_mode    = w_vs_rise ? mode_e'(cfg_mode) : r_mode;
    assign w_row0    = w_vs_rise | (r_row == '0);
    assign w_row1    = ~w_vs_rise & (r_row == RW'(1));
    assign w_c0      = (r_col == '0);
    assign w_c1      = (r_col == CW'(1));
    assign w_tcol    = (r_col >= CW'(IMG_WIDTH)) ? AW'(IMG_WIDTH - 1) : r_col[AW-1:0];

    image_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .IMG_WIDTH  (IMG_WIDTH),
        .AW         (AW)
    ) u_lbuf (
        .i_clk  (clk),
        .i_we   (w_acc & ~w_ovf),
        .i_addr (w_tcol),
        .i_din  (per_img_gray),
        .o_row1 (w_lb1),
        .o_row2 (w_lb2)
    );

    // Vertical clamp: rows above the frame replicate row 0.
    assign w_colv[2] = per_img_gray;
    assign w_colv[1] = w_row0 ? per_img_gray : w_lb1;
    assign w_colv[0] = w_row0 ? per_img_gray : (w_row1 ? w_lb1 : w_lb2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_d  <= 1'b0;
            r_hr_d  <= 1'b0;
            r_armed <= 1'b0;
            r_ovf   <= 1'b0;
            r_col   <= '0;
            r_row   <= '0;
            r_mode  <= MODE_BYPASS;
        end else begin
            r_vs_d <= per_frame_vsync;
            r_hr_d <= per_frame_href;
            if (w_vs_rise) begin
                r_armed <= 1'b1;
                r_mode  <= mode_e'(cfg_mode);
            end
            if (w_en) begin
                if (w_vs_rise)      r_row <= '0;
                else if (w_hr_fall) r_row <= r_row + RW'(1);
                if (w_hr_fall)                          r_col <= '0;
                else if (w_acc && !w_ovf)               r_col <= r_col + CW'(1);
                if (w_vs_rise)  r_ovf <= 1'b0;
                else if (w_ovf) r_ovf <= 1'b1;
            end
        end
    end

    // Stage 1: horizontal clamp and window load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cm1     <= '0;
            r_cm2     <= '0;
            r_win     <= '0;
            r_mode_s1 <= MODE_BYPASS;
        end else if (w_acc) begin
            r_cm1     <= w_colv;
            r_cm2     <= r_cm1;
            r_mode_s1 <= w_mode;
            for (int i = 0; i < 3; i++) begin
                r_win[i][2] <= w_colv[i];
                r_win[i][1] <= w_c0 ? w_colv[i] : r_cm1[i];
                r_win[i][0] <= w_c0 ? w_colv[i] : (w_c1 ? r_cm1[i] : r_cm2[i]);
            end
        end
    end

    always_comb begin
        w_prod = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w_prod[i][j] = ACC_W'(r_win[i][j]) * ACC_W'(kweight(r_mode_s1, 4'(i*3 + j)));
    end

    // Stage 2: weighted row partial sums.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsum    <= '0;
            r_mode_s2 <= MODE_BYPASS;
        end else if (r_vld_pipe[0]) begin
            r_mode_s2 <= r_mode_s1;
            for (int i = 0; i < 3; i++)
                r_rsum[i] <= w_prod[i][0] + w_prod[i][1] + w_prod[i][2];
        end
    end

    // Stage 3: final sum, round-to-nearest, normalise.
    assign w_sum = r_rsum[0] + r_rsum[1] + r_rsum[2];
    assign w_sh  = kshift(r_mode_s2);
    assign w_rnd = (w_sh == 3'd0) ? '0 : (ACC_W'(1) << (w_sh - 3'd1));
    assign w_res = (w_sum + w_rnd) >> w_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gray     <= '0;
            r_vld_pipe <= '0;
            r_vs_pipe  <= '0;
            r_hr_pipe  <= '0;
            r_ck_pipe  <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], w_acc};
            r_vs_pipe  <= {r_vs_pipe[PIPE_LAT-2:0], per_frame_vsync & w_en};
            r_hr_pipe  <= {r_hr_pipe[PIPE_LAT-2:0], per_frame_href  & w_en};
            r_ck_pipe  <= {r_ck_pipe[PIPE_LAT-2:0], per_frame_clken & w_en};
            if (r_vld_pipe[1]) r_gray <= DATA_WIDTH'(w_res);
        end
    end

    assign post_frame_vsync = r_vs_pipe[PIPE_LAT-1];
    assign post_frame_href  = r_hr_pipe[PIPE_LAT-1];
    assign post_frame_clken = r_ck_pipe[PIPE_LAT-1];
    assign post_img_gray    = r_gray;
    assign line_overflow    = r_ovf;

endmodule

// File: tb/tb_image_gaussian_filter_cfg.sv
// Bench for image_gaussian_filter_cfg: directed probe table plus randomized
// frames scored against a coordinate-level reference model.
module tb_image_gaussian_filter_cfg;

    localparam int DW = 8;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    cfg_mode = 2'd0;
    logic          vsync = 1'b0, href = 1'b0, clken = 1'b0;
    logic [DW-1:0] gray = '0;
    logic          post_vs, post_hr, post_ck, ovf;
    logic [DW-1:0] post_gray;

    image_gaussian_filter_cfg #(.DATA_WIDTH(DW), .IMG_WIDTH(IW)) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_mode         (cfg_mode),
        .per_frame_vsync  (vsync),
        .per_frame_href   (href),
        .per_frame_clken  (clken),
        .per_img_gray     (gray),
        .post_frame_vsync (post_vs),
        .post_frame_href  (post_hr),
        .post_frame_clken (post_ck),
        .post_img_gray    (post_gray),
        .line_overflow    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct { int val; int chk; int r; int c; } exp_t;
    typedef struct { int mode; int kind; int h; int w; int pr; int pc; int expv; } vec_t;

    int   checks = 0, errors = 0;
    int   frame [0:7][0:9];
    int   got   [0:7][0:9];
    exp_t exp_q [$];
    logic [2:0] hist [$];
    logic prev_vs = 1'b0, tb_armed = 1'b0;

    task automatic check(input string nm, input int actual, input int expv);
        checks++;
        if (actual != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, actual, expv, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: weighted 3x3 window centred on (r-1,c-1), coordinates clamped at 0.
    function automatic int ref_out(input int mode, input int r, input int c);
        int sum = 0;
        if (mode != 1 && mode != 2) return frame[r][c];
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++) begin
                int rr = (r - 2 + dr < 0) ? 0 : r - 2 + dr;
                int cc = (c - 2 + dc < 0) ? 0 : c - 2 + dc;
                int wt;
                if (mode == 1) wt = ((dr == 1) ? 2 : 1) * ((dc == 1) ? 2 : 1);
                else           wt = (dr == 1 && dc == 1) ? 4 : ((dr == 1 || dc == 1) ? 1 : 0);
                sum += wt * frame[rr][cc];
            end
        return (mode == 1) ? (sum + 8) >> 4 : (sum + 4) >> 3;
    endfunction

    task automatic fill(input int kind);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 10; c++) begin
                case (kind)
                    0: frame[r][c] = 100;
                    1: frame[r][c] = (r == 2 && c == 2) ? 160 : 0;
                    2: frame[r][c] = (r == 2 && c == 2) ? 1 : 0;
                    3: frame[r][c] = 16 * c;
                    default: frame[r][c] = int'($urandom_range(0, 255));
                endcase
                got[r][c] = -1;
            end
    endtask

    task automatic play_frame(input int mode, input int h, input int w, input int gaps,
                              input int chg, input int ovf_w, input int rst_row);
        int live = 1;
        int chk  = (ovf_w == 0) ? 1 : 0;
        int lw;
        exp_t e;
        cfg_mode = 2'(mode);
        step(1);
        vsync = 1'b1;
        step(2);
        check("ovf_clear_on_vsync", int'(ovf), 0);
        vsync = 1'b0;
        step(2);
        for (int r = 0; r < h; r++) begin
            if (r == rst_row) begin
                rst = 1'b1;
                #1;
                check("rst_outputs_zero", int'({post_vs, post_hr, post_ck, post_gray, ovf}), 0);
                step(3);
                rst  = 1'b0;
                live = 0;
            end
            if (r == 1 && chg >= 0) cfg_mode = 2'(chg);
            href = 1'b1;
            lw   = (r == 0 && ovf_w > 0) ? ovf_w : w;
            for (int c = 0; c < lw; c++) begin
                if (gaps != 0)
                    while ($urandom_range(0, 2) == 0) begin clken = 1'b0; step(1); end
                clken = 1'b1;
                gray  = DW'(frame[r][c]);
                if (live != 0) begin
                    e = '{ref_out(mode, r, c), chk, r, c};
                    exp_q.push_back(e);
                end
                if (ovf_w > 0 && c == IW) check("ovf_before_9th", int'(ovf), 0);
                step(1);
                if (ovf_w > 0 && c >= IW) check("ovf_set", int'(ovf), 1);
                clken = 1'b0;
            end
            href = 1'b0;
            step(2);
        end
        step(6);
    endtask

    // Output monitor: sync path is the gated input stream delayed 3 cycles.
    always @(negedge clk) begin
        if (rst) begin
            check("reset_outputs", int'({post_vs, post_hr, post_ck, post_gray, ovf}), 0);
            hist = '{3'b000, 3'b000, 3'b000};
            exp_q.delete();
            prev_vs  = 1'b0;
            tb_armed = 1'b0;
        end else begin
            logic rise, en;
            logic [2:0] want;
            exp_t e;
            rise     = vsync & ~prev_vs;
            prev_vs  = vsync;
            en       = tb_armed | rise;
            tb_armed = tb_armed | rise;
            want     = hist.pop_front();
            check("sync_delay3", int'({post_vs, post_hr, post_ck}), int'(want));
            hist.push_back(en ? {vsync, href, clken} : 3'b000);
            if (post_hr && post_ck) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    got[e.r][e.c] = int'(post_gray);
                    if (e.chk != 0) check("pixel_vs_model", int'(post_gray), e.val);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected 0", 1);
        $fatal(1);
    end

    initial begin
        vec_t vecs [15];
        vecs = '{
            '{1, 0, 4, 8, 0, 0, 100}, '{1, 0, 4, 8, 3, 7, 100},
            '{1, 1, 5, 5, 3, 3, 40},  '{1, 1, 5, 5, 3, 4, 20},
            '{1, 1, 5, 5, 4, 4, 10},  '{1, 1, 5, 5, 4, 3, 20},
            '{1, 1, 5, 5, 2, 2, 10},  '{2, 2, 5, 5, 3, 3, 1},
            '{2, 2, 5, 5, 3, 4, 0},   '{1, 3, 3, 8, 0, 0, 0},
            '{1, 3, 3, 8, 0, 1, 4},   '{1, 3, 3, 8, 0, 2, 16},
            '{2, 3, 3, 8, 0, 2, 16},  '{0, 3, 3, 8, 1, 3, 48},
            '{3, 1, 5, 5, 2, 2, 160}
        };
        step(3);
        rst = 1'b0;
        step(3);

        // Directed probes
        for (int i = 0; i < 15; i++) begin
            fill(vecs[i].kind);
            play_frame(vecs[i].mode, vecs[i].h, vecs[i].w, i % 2, -1, 0, -1);
            check($sformatf("vec%0d_px(%0d,%0d)", i, vecs[i].pr, vecs[i].pc),
                  got[vecs[i].pr][vecs[i].pc], vecs[i].expv);
        end

        // Mid-frame mode change takes effect only at the next frame
        fill(4);
        play_frame(1, 5, 7, 1, 0, 0, -1);
        fill(4);
        play_frame(0, 4, 6, 1, -1, 0, -1);
        fill(4);
        play_frame(0, 4, 6, 0, 2, 0, -1);

        // Overflow line, then a normal frame
        fill(4);
        play_frame(1, 2, 8, 0, -1, 10, -1);
        check("ovf_sticky_after_frame", int'(ovf), 1);
        fill(4);
        play_frame(1, 4, 8, 1, -1, 0, -1);

        // Reset in the middle of row 2, then a clean frame
        fill(4);
        play_frame(1, 5, 6, 0, -1, 0, 2);
        fill(4);
        play_frame(2, 5, 6, 1, -1, 0, -1);

        // Randomized frames
        for (int k = 0; k < 6; k++) begin
            fill(4);
            play_frame(int'($urandom_range(0, 3)), int'($urandom_range(3, 6)),
                       int'($urandom_range(3, 8)), 1, -1, 0, -1);
        end

        check("expected_queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
